// File: rtl/dm_arb_pkg.sv
// Shared constants and types for the dm_4k two-port arbiter.
package dm_arb_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_RESP   = 2'd2;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_DBG = 1'b1;

   typedef enum logic [1:0] {
      StIdle   = ST_IDLE,
      StAccess = ST_ACCESS,
      StResp   = ST_RESP
   } dm_arb_state_e;

endpackage

// File: rtl/dm_4k.sv
// 4 KB word-addressed data memory: synchronous write, combinational read.
module dm_4k (
   input  logic [11:2] addr,
   input  logic [31:0] din,
   input  logic        we,
   input  logic        clk,
   output logic [31:0] dout
);

   logic [31:0] mem_q [1024];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[addr] <= din;
      end
   end

   assign dout = mem_q[addr];

endmodule

// File: rtl/dm_arb_rr2.sv
// Two-way round-robin picker; on a tie the port that was not granted last wins.
module dm_arb_rr2
   import dm_arb_pkg::*;
(
   input  logic req0_i,
   input  logic req1_i,
   input  logic last_i,
   output logic gnt0_o,
   output logic gnt1_o,
   output logic sel_o
);

   always_comb begin
      gnt0_o = req0_i & (~req1_i | (last_i == PORT_DBG));
      gnt1_o = req1_i & (~req0_i | (last_i == PORT_CPU));
      sel_o  = gnt1_o ? PORT_DBG : PORT_CPU;
   end

endmodule

// File: rtl/dm_arbiter.sv
// Round-robin arbiter/sequencer sharing dm_4k between CPU and debug ports.
// Optional grant counters are enabled by defining DM_ARB_STATS_EN.
module dm_arbiter
   import dm_arb_pkg::*;
#(
   parameter int unsigned AW   = 10,
   parameter int unsigned DW   = 32,
   parameter int unsigned CNTW = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req0_i,
   input  logic            req1_i,
   input  logic            we0_i,
   input  logic            we1_i,
   input  logic [AW+1:2]   addr0_i,
   input  logic [AW+1:2]   addr1_i,
   input  logic [DW-1:0]   wdata0_i,
   input  logic [DW-1:0]   wdata1_i,
   output logic            gnt0_o,
   output logic            gnt1_o,
   output logic            rvalid0_o,
   output logic            rvalid1_o,
   output logic [DW-1:0]   rdata0_o,
   output logic [DW-1:0]   rdata1_o,
   output logic [AW+1:2]   dm_addr_o,
   output logic [DW-1:0]   dm_din_o,
   output logic            dm_we_o,
   input  logic [DW-1:0]   dm_dout_i,
   output logic [CNTW-1:0] gcnt0_o,
   output logic [CNTW-1:0] gcnt1_o
);

   dm_arb_state_e  state_q;
   logic           last_q;
   logic           owner_q;
   logic [AW+1:2]  dm_addr_q;
   logic [DW-1:0]  dm_din_q;
   logic           dm_we_q;
   logic           rvalid0_q;
   logic           rvalid1_q;
   logic [DW-1:0]  rdata0_q;
   logic [DW-1:0]  rdata1_q;

   logic idle;
   logic rr_gnt0;
   logic rr_gnt1;
   logic rr_sel;

   assign idle = (state_q == StIdle);

   // Requests are only offered to the picker in IDLE, so grants cannot appear elsewhere.
   dm_arb_rr2 u_rr2 (
      .req0_i (req0_i & idle),
      .req1_i (req1_i & idle),
      .last_i (last_q),
      .gnt0_o (rr_gnt0),
      .gnt1_o (rr_gnt1),
      .sel_o  (rr_sel)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         last_q    <= PORT_DBG;
         owner_q   <= PORT_CPU;
         dm_addr_q <= '0;
         dm_din_q  <= '0;
         dm_we_q   <= 1'b0;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
         rdata0_q  <= '0;
         rdata1_q  <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (rr_gnt0 | rr_gnt1) begin
                  owner_q   <= rr_sel;
                  last_q    <= rr_sel;
                  dm_addr_q <= (rr_sel == PORT_DBG) ? addr1_i : addr0_i;
                  dm_din_q  <= (rr_sel == PORT_DBG) ? wdata1_i : wdata0_i;
                  dm_we_q   <= (rr_sel == PORT_DBG) ? we1_i : we0_i;
                  state_q   <= StAccess;
               end
            end
            StAccess: begin
               // Writes also return the pre-write word as their acknowledge data.
               dm_we_q <= 1'b0;
               if (owner_q == PORT_DBG) begin
                  rdata1_q <= dm_dout_i;
               end else begin
                  rdata0_q <= dm_dout_i;
               end
               rvalid0_q <= (owner_q == PORT_CPU);
               rvalid1_q <= (owner_q == PORT_DBG);
               state_q   <= StResp;
            end
            StResp: begin
               rvalid0_q <= 1'b0;
               rvalid1_q <= 1'b0;
               state_q   <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign gnt0_o    = rr_gnt0;
   assign gnt1_o    = rr_gnt1;
   assign rvalid0_o = rvalid0_q;
   assign rvalid1_o = rvalid1_q;
   assign rdata0_o  = rdata0_q;
   assign rdata1_o  = rdata1_q;
   assign dm_addr_o = dm_addr_q;
   assign dm_din_o  = dm_din_q;
   assign dm_we_o   = dm_we_q;

`ifdef DM_ARB_STATS_EN
   localparam logic [CNTW-1:0] CntOne = {{(CNTW-1){1'b0}}, 1'b1};

   logic [CNTW-1:0] gcnt0_q;
   logic [CNTW-1:0] gcnt1_q;

   // Saturating counters: they stick at all-ones until reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gcnt0_q <= '0;
         gcnt1_q <= '0;
      end else begin
         if (rr_gnt0 && (gcnt0_q != '1)) begin
            gcnt0_q <= gcnt0_q + CntOne;
         end
         if (rr_gnt1 && (gcnt1_q != '1)) begin
            gcnt1_q <= gcnt1_q + CntOne;
         end
      end
   end

   assign gcnt0_o = gcnt0_q;
   assign gcnt1_o = gcnt1_q;
`else
   assign gcnt0_o = '0;
   assign gcnt1_o = '0;
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter with the real dm_4k and a CNTW=2 twin for saturation.
module tb_dm_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
   logic [11:2] addr0 = '0, addr1 = '0;
   logic [31:0] wdata0 = '0, wdata1 = '0;
   logic        gnt0, gnt1, rvalid0, rvalid1, dm_we;
   logic [31:0] rdata0, rdata1, dm_din, dm_dout;
   logic [11:2] dm_addr;
   logic [15:0] gcnt0, gcnt1;

   logic        s_gnt0, s_gnt1, s_rvalid0, s_rvalid1, s_dm_we;
   logic [31:0] s_rdata0, s_rdata1, s_dm_din;
   logic [11:2] s_dm_addr;
   logic [1:0]  s_gcnt0, s_gcnt1;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int g0_n = 0;
   int g1_n = 0;

   typedef struct {
      bit          port;
      int          cyc;
      bit          chk;
      logic [31:0] data;
   } exp_t;
   exp_t sbq[$];

   typedef struct {
      bit          port;
      bit          we;
      logic [9:0]  addr;
      logic [31:0] wdata;
      bit          chk;
      logic [31:0] exp;
   } vec_t;
   vec_t tbl[7];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   dm_arbiter u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req0_i    (req0),
      .req1_i    (req1),
      .we0_i     (we0),
      .we1_i     (we1),
      .addr0_i   (addr0),
      .addr1_i   (addr1),
      .wdata0_i  (wdata0),
      .wdata1_i  (wdata1),
      .gnt0_o    (gnt0),
      .gnt1_o    (gnt1),
      .rvalid0_o (rvalid0),
      .rvalid1_o (rvalid1),
      .rdata0_o  (rdata0),
      .rdata1_o  (rdata1),
      .dm_addr_o (dm_addr),
      .dm_din_o  (dm_din),
      .dm_we_o   (dm_we),
      .dm_dout_i (dm_dout),
      .gcnt0_o   (gcnt0),
      .gcnt1_o   (gcnt1)
   );

   dm_4k u_mem (
      .addr (dm_addr),
      .din  (dm_din),
      .we   (dm_we),
      .clk  (clk),
      .dout (dm_dout)
   );

   dm_arbiter #(.CNTW(2)) u_small (
      .clk       (clk),
      .rst_n     (rst_n),
      .req0_i    (req0),
      .req1_i    (req1),
      .we0_i     (we0),
      .we1_i     (we1),
      .addr0_i   (addr0),
      .addr1_i   (addr1),
      .wdata0_i  (wdata0),
      .wdata1_i  (wdata1),
      .gnt0_o    (s_gnt0),
      .gnt1_o    (s_gnt1),
      .rvalid0_o (s_rvalid0),
      .rvalid1_o (s_rvalid1),
      .rdata0_o  (s_rdata0),
      .rdata1_o  (s_rdata1),
      .dm_addr_o (s_dm_addr),
      .dm_din_o  (s_dm_din),
      .dm_we_o   (s_dm_we),
      .dm_dout_i (dm_dout),
      .gcnt0_o   (s_gcnt0),
      .gcnt1_o   (s_gcnt1)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int sat(input int n, input int mx);
      return (n > mx) ? mx : n;
   endfunction

   // dm_we must follow a write grant by exactly one cycle and carry the granted address/data.
   logic        exp_we_n = 1'b0;
   logic [9:0]  exp_addr_n = '0;
   logic [31:0] exp_din_n = '0;
   always @(negedge clk) begin
      logic e;
      e = rst_n ? exp_we_n : 1'b0;
      chk("dm_we", dm_we, e);
      if (e) begin
         chk("dm_addr", dm_addr, exp_addr_n);
         chk("dm_din", dm_din, exp_din_n);
      end
      exp_we_n   = rst_n && ((gnt0 && we0) || (gnt1 && we1));
      exp_addr_n = gnt1 ? addr1 : addr0;
      exp_din_n  = gnt1 ? wdata1 : wdata0;
   end

   // Response scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (rvalid0 && rvalid1) begin
         checks++;
         errors++;
         $display("FAIL rvalid_both: got 11 expected one-hot");
      end else if (rvalid0 || rvalid1) begin
         checks++;
         if (sbq.size() == 0) begin
            errors++;
            $display("FAIL rvalid_unexpected: got rvalid%0d=1 expected 0", rvalid1);
         end else begin
            e = sbq.pop_front();
            chk("rvalid_port", {31'd0, rvalid1}, {31'd0, e.port});
            chk("rvalid_latency", cyc - e.cyc, 2);
            if (e.chk) chk("rdata", e.port ? rdata1 : rdata0, e.data);
         end
      end
   end

   task automatic drain();
      int n = 0;
      while (sbq.size() != 0 && n < 10) begin
         @(posedge clk);
         n++;
      end
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL resp_timeout: got %0d pending expected 0", sbq.size());
         sbq.delete();
      end
   endtask

   task automatic txn(input bit p, input bit w, input logic [9:0] a, input logic [31:0] d,
                      input bit c, input logic [31:0] e);
      int  n = 0;
      bit  got = 0;
      exp_t x;
      #1;
      if (p) begin
         req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d;
      end else begin
         req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d;
      end
      while (!got && n < 20) begin
         @(negedge clk);
         if (p ? gnt1 : gnt0) got = 1;
         else n++;
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL gnt_timeout: got no gnt%0d expected gnt", p);
      end else begin
         chk("gnt_other", p ? gnt0 : gnt1, 0);
         chk("gnt_latency", n, 0);
         x.port = p; x.cyc = cyc; x.chk = c; x.data = e;
         sbq.push_back(x);
         if (p) g1_n++;
         else g0_n++;
      end
      @(posedge clk);
      #1;
      req0 = 1'b0;
      req1 = 1'b0;
   endtask

   task automatic chk_stats();
`ifdef DM_ARB_STATS_EN
      chk("gcnt0", gcnt0, g0_n);
      chk("gcnt1", gcnt1, g1_n);
      chk("gcnt0_sat", s_gcnt0, sat(g0_n, 3));
      chk("gcnt1_sat", s_gcnt1, sat(g1_n, 3));
`else
      chk("gcnt0_off", gcnt0, 0);
      chk("gcnt1_off", gcnt1, 0);
      chk("gcnt0_sat_off", s_gcnt0, 0);
      chk("gcnt1_sat_off", s_gcnt1, 0);
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t x;
      int   n;
      bit   p;
      int   last_gc;

      tbl[0] = '{0, 1, 10'h003, 32'habcd_0eff, 0, 32'h0};
      tbl[1] = '{0, 0, 10'h003, 32'h0,         1, 32'habcd_0eff};
      tbl[2] = '{1, 1, 10'h3fc, 32'h5432_f100, 0, 32'h0};
      tbl[3] = '{1, 0, 10'h3fc, 32'h0,         1, 32'h5432_f100};
      tbl[4] = '{0, 1, 10'h003, 32'h1111_2222, 1, 32'habcd_0eff};
      tbl[5] = '{1, 0, 10'h003, 32'h0,         1, 32'h1111_2222};
      tbl[6] = '{1, 1, 10'h3fc, 32'h5432_f100, 1, 32'h5432_f100};

      // Reset state.
      repeat (3) begin
         @(negedge clk);
         chk("rst_gnt", {gnt1, gnt0}, 0);
         chk("rst_rvalid", {rvalid1, rvalid0}, 0);
         chk("rst_rdata0", rdata0, 0);
         chk("rst_rdata1", rdata1, 0);
         chk("rst_dm_addr", dm_addr, 0);
         chk("rst_dm_din", dm_din, 0);
         chk("rst_gcnt", {gcnt1, gcnt0}, 0);
      end
      #1 rst_n = 1'b1;
      @(posedge clk);

      foreach (tbl[i]) begin
         txn(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].chk, tbl[i].exp);
         drain();
      end

      // Contention: both ports hold requests for four transactions.
      #1;
      req0 = 1'b1; we0 = 1'b0; addr0 = 10'h3fc;
      req1 = 1'b1; we1 = 1'b0; addr1 = 10'h3fc;
      p = 0;
      last_gc = 0;
      for (int k = 0; k < 4; k++) begin
         n = 0;
         @(negedge clk);
         while (!(gnt0 || gnt1) && n < 10) begin
            @(negedge clk);
            n++;
         end
         chk("cont_gnt_port", {gnt1, gnt0}, p ? 2'b10 : 2'b01);
         if (k > 0) chk("cont_spacing", cyc - last_gc, 3);
         last_gc = cyc;
         x.port = p; x.cyc = cyc; x.chk = 1; x.data = 32'h5432_f100;
         sbq.push_back(x);
         if (p) g1_n++;
         else g0_n++;
         p = ~p;
      end
      @(posedge clk);
      #1;
      req0 = 1'b0;
      req1 = 1'b0;
      drain();

      // Request raised while busy waits for the next IDLE.
      #1;
      req0 = 1'b1; we0 = 1'b0; addr0 = 10'h3fc;
      @(negedge clk);
      chk("busy_gnt0", gnt0, 1);
      x.port = 0; x.cyc = cyc; x.chk = 1; x.data = 32'h5432_f100;
      sbq.push_back(x);
      g0_n++;
      @(posedge clk);
      #1;
      req0 = 1'b0;
      req1 = 1'b1; we1 = 1'b0; addr1 = 10'h003;
      @(negedge clk);
      chk("busy_gnt1_access", gnt1, 0);
      @(negedge clk);
      chk("busy_gnt1_resp", gnt1, 0);
      @(negedge clk);
      chk("busy_gnt1_idle", gnt1, 1);
      x.port = 1; x.cyc = cyc; x.chk = 1; x.data = 32'h1111_2222;
      sbq.push_back(x);
      g1_n++;
      @(posedge clk);
      #1;
      req1 = 1'b0;
      drain();
      chk_stats();

      // Reset in the middle of a port 1 write.
      #1;
      req1 = 1'b1; we1 = 1'b1; addr1 = 10'h010; wdata1 = 32'hdead_beef;
      @(negedge clk);
      chk("mid_gnt1", gnt1, 1);
      @(posedge clk);
      #1;
      req1 = 1'b0;
      chk("mid_we_access", dm_we, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_we_async", dm_we, 0);
      chk("mid_rvalid", {rvalid1, rvalid0}, 0);
      sbq.delete();
      g0_n = 0;
      g1_n = 0;
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("post_rst_rvalid", {rvalid1, rvalid0}, 0);
      end
      chk_stats();
      @(posedge clk);

      // Stats: five grants to port 0, three to port 1, then a sixth to port 0.
      for (int k = 0; k < 5; k++) begin
         txn(0, 0, 10'h003, 32'h0, 1, 32'h1111_2222);
         drain();
      end
      for (int k = 0; k < 3; k++) begin
         txn(1, 0, 10'h3fc, 32'h0, 1, 32'h5432_f100);
         drain();
      end
      chk_stats();
      txn(0, 0, 10'h003, 32'h0, 1, 32'h1111_2222);
      drain();
      chk_stats();

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
